sobel_stream: RTL
=================

# sobel_stream

Parametrised streaming Sobel edge detector: accepts one grey pixel per valid cycle in raster order and emits one filtered pixel per accepted input at fixed latency. It sits between the camera capture / colour-to-grey stage and the HDMI output path. It replaces fixed 512-column sync-derived windowing with:
- explicit start-of-frame framing,
- parametrised image size and pixel width,
- selectable output modes,
- defined border handling.

## Interface
- DATA_W, 8, pixel width in bits (in and out)
- IMG_W, 640, active pixels per line; line buffer depth
- IMG_H, 480, active lines per frame
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data/in_sof valid this cycle; gaps allowed anywhere
- in_sof  in  1  marks first pixel of a frame; meaningful only with in_valid
- in_data  in  DATA_W  grey pixel
- mode  in  2  0 = threshold, 1 = saturated magnitude, 2 = magnitude>>3, 3 = centre-pixel passthrough
- threshold  in  DATA_W+3  threshold for mode 0
- out_valid  out  1  out_data valid
- out_sof  out  1  first output pixel of a frame
- out_data  out  DATA_W  filtered pixel
- frame_err  out  1  one-cycle pulse on a framing violation

## Operation
- States:
  - IDLE (reset state): in_valid without in_sof is dropped silently, with no output. in_valid with in_sof → ACTIVE; that pixel is (row 0, col 0).
  - ACTIVE: each accepted pixel advances col. col wraps IMG_W-1→0 with row+1. The pixel at (IMG_H-1, IMG_W-1) is accepted and the state returns to IDLE.
- in_sof in ACTIVE (mid-frame):
  - frame_err pulses.
  - Counters restart at (0,0) with this pixel, which is processed as the first pixel of a new frame.
- mode and threshold are sampled when an in_sof pixel is accepted and held for the frame. Changes mid-frame have no effect.
- Two line buffers of IMG_W×DATA_W hold rows r-1 and r-2. They are written/shifted only on accepted pixels.
- The 3×3 window uses rows r-2, r-1, r and columns c-2, c-1, c, giving output centre (r-1, c-1).
- Window notation: p[i][j], where i = row offset 0..2 (top to bottom) and j = column offset 0..2 (left to right).
- Gradients (signed, DATA_W+3 bits, no overflow possible):
  - Gx = (p02 + 2p12 + p22) − (p00 + 2p10 + p20)
  - Gy = (p20 + 2p21 + p22) − (p00 + 2p01 + p02)
- mag = |Gx| + |Gy|, unsigned DATA_W+3 bits. Maximum is 8·(2^DATA_W−1), which fits.
- Output by mode:
  - mode 0: all-ones if mag > threshold, else 0.
  - mode 1: min(mag, 2^DATA_W−1).
  - mode 2: (mag>>3), truncated to DATA_W.
  - mode 3: p11.
- Border: if r<2 or c<2 (window incomplete or straddling a line), out_data = 0 in every mode. Output count per frame is exactly IMG_W·IMG_H.
- Line buffer contents are never cleared; border masking makes stale data invisible.

## Timing
- Input accepted at cycle t → out_valid at t+2 with the corresponding out_data; out_sof at t+2 for an in_sof pixel.
- One output per accepted input, order preserved, no backpressure. Input gaps produce identical output gaps.
- frame_err is registered: it is high at t+1 for an offending in_sof accepted at t.
- Reset values: out_valid 0, out_sof 0, out_data 0, frame_err 0, state IDLE, counters 0, sampled mode/threshold 0.
- Reset mid-frame: in-flight pipeline outputs are discarded (out_valid 0 from the cycle after reset). Subsequent pixels are dropped until the next in_sof.
- in_sof on the final pixel position of a frame is treated as a new frame start with frame_err.

## Structure
- Package sobel_pkg: mode encodings (MODE_THRESH, MODE_SAT, MODE_SHIFT, MODE_PASS), state encodings, and a function deriving MAG_W = DATA_W+3.
- Sub-module sobel_line_buffer:
  - Single-port-per-side RAM, depth IMG_W, width 2·DATA_W, holding both delayed rows in one word.
  - Synchronous read and write at the same address per accepted pixel; read-before-write semantics.
- Top level: framing FSM and row/col counters, window registers, gradient/magnitude pipeline, output mux.

## Test plan
- IMG_W=8, IMG_H=6, constant 100, mode 1 → 48 outputs, all 0. out_sof only on the first output, 2 cycles after the in_sof pixel.
- Same size, columns 0–3 = 0, columns 4–7 = 255, mode 1 → rows 1–4, columns 3 and 4 = 255; all others 0. mode 0 with threshold 127 → same result. mode 2 → those pixels = 127.
- Random in_valid gaps (30 % duty), mode 3 on a ramp image → out_data equals the centre pixel and is 0 on the border. Every output appears exactly 2 cycles after its input; output gaps mirror input gaps.
- in_sof reasserted at pixel index 20 → frame_err high for exactly one cycle, row/col restart, out_sof 2 cycles later, 48 further outputs.
- reset asserted for 1 cycle at pixel 30 → out_valid 0 from the next cycle. Pixels without in_sof produce no output and no frame_err. The next in_sof frame is processed normally.
- mode changed 1→0 mid-frame → the current frame stays in mode 1; the next frame uses mode 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared encodings and width helpers for the streaming Sobel edge detector.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_PASS   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Gradient/magnitude width: 3 guard bits cover the 8x worst-case magnitude.
  function automatic int mag_width(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel stream bundle: valid strobe, start-of-frame marker and grey pixel.
interface sobel_stream_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              sof;
  logic [DATA_W-1:0] data;

  modport master (output valid, sof, data);
  modport slave  (input  valid, sof, data);
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer packed into one RAM word: {row r-2, row r-1} per column.
// The read for a pixel happens on its accept edge; the shifted word is written
// back one cycle later from the registered read data, so each side of the RAM
// uses a single port.
module sobel_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [((IMG_W > 1) ? $clog2(IMG_W) : 1)-1:0] addr,
  input  logic [DATA_W-1:0]             din,
  output logic [2*DATA_W-1:0]           q
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [2*DATA_W-1:0] mem [IMG_W];
  logic                wr_pend;
  logic [AW-1:0]       wr_addr;
  logic [DATA_W-1:0]   wr_din;
  logic [2*DATA_W-1:0] wr_word;

  // Old row r-1 becomes row r-2; the new pixel becomes row r-1.
  assign wr_word = {q[DATA_W-1:0], wr_din};

  // Read port; forward a pending write to the same column (tiny images only).
  always_ff @(posedge clk) begin
    if (en) begin
      q <= (wr_pend && (wr_addr == addr)) ? wr_word : mem[addr];
    end
  end

  // Write port, one cycle behind the read of the same pixel.
  always_ff @(posedge clk) begin
    if (wr_pend) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Pending-write flag is control and is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= en;
    end
  end

  // Capture address and pixel for the delayed write.
  always_ff @(posedge clk) begin
    if (en) begin
      wr_addr <= addr;
      wr_din  <= din;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with start-of-frame framing, border
// masking and selectable output mode. Fixed two-cycle input-to-output latency.
module sobel_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              reset,
  sobel_stream_if.slave     in_s,
  sobel_stream_if.master    out_s,
  input  logic [1:0]        mode,
  input  logic [DATA_W+2:0] threshold,
  output logic              frame_err
);
  import sobel_pkg::*;

  localparam int MAG_W = mag_width(DATA_W);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e             state;
  logic [COL_W-1:0]   col_cnt;
  logic [ROW_W-1:0]   row_cnt;
  mode_e              mode_q;
  logic [MAG_W-1:0]   thr_q;

  logic               accept;
  logic [COL_W-1:0]   pos_col;
  logic [ROW_W-1:0]   pos_row;
  logic               last_col;
  logic               last_row;

  logic               vld_p0;
  logic               sof_p0;
  logic               border_p0;
  logic [DATA_W-1:0]  pix_p0;
  logic [2*DATA_W-1:0] lb_q;
  logic [2:0][DATA_W-1:0] cur_p0;

  logic [2:0][DATA_W-1:0] wl_p1;
  logic [2:0][DATA_W-1:0] wm_p1;

  logic signed [MAG_W-1:0] gx;
  logic signed [MAG_W-1:0] gy;
  logic [MAG_W-1:0]        mag;
  logic [DATA_W-1:0]       mode_out;

  logic               vld_p1;
  logic               sof_p1;
  logic [DATA_W-1:0]  data_p1;

  function automatic logic signed [MAG_W-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic [MAG_W-1:0] abs_g(input logic signed [MAG_W-1:0] g);
    return (g < 0) ? MAG_W'(-g) : MAG_W'(g);
  endfunction

  function automatic logic [DATA_W-1:0] sat_mag(input logic [MAG_W-1:0] m);
    return (|m[MAG_W-1:DATA_W]) ? {DATA_W{1'b1}} : m[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_mag(input logic [MAG_W-1:0] m);
    return DATA_W'(m >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] thresh_mag(input logic [MAG_W-1:0] m,
                                                   input logic [MAG_W-1:0] t);
    return (m > t) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  // A frame start is always accepted; other pixels only inside a frame.
  assign accept   = in_s.valid && (in_s.sof || (state == ST_ACTIVE));
  assign pos_col  = in_s.sof ? '0 : col_cnt;
  assign pos_row  = in_s.sof ? '0 : row_cnt;
  assign last_col = (pos_col == COL_W'(IMG_W - 1));
  assign last_row = (pos_row == ROW_W'(IMG_H - 1));

  // Framing FSM: raster counters, per-frame mode capture, framing error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      mode_q    <= MODE_THRESH;
      thr_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && in_s.sof && (state == ST_ACTIVE);
      if (accept) begin
        if (in_s.sof) begin
          mode_q <= mode_e'(mode);
          thr_q  <= threshold;
        end
        if (last_col) begin
          col_cnt <= '0;
          if (last_row) begin
            row_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            row_cnt <= pos_row + ROW_W'(1);
            state   <= ST_ACTIVE;
          end
        end else begin
          col_cnt <= pos_col + COL_W'(1);
          row_cnt <= pos_row;
          state   <= ST_ACTIVE;
        end
      end
    end
  end

  sobel_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_lb (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .addr  (pos_col),
    .din   (in_s.data),
    .q     (lb_q)
  );

  // ---- stage p0: accepted pixel + line-buffer column read ----

  // Valid for stage p0 is control and is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  // Stage p0 data: pixel, frame marker and border flag for centre (r-1, c-1).
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p0    <= in_s.data;
      sof_p0    <= in_s.sof;
      border_p0 <= (pos_row < ROW_W'(2)) || (pos_col < COL_W'(2));
    end
  end

  // Newest window column, top (row r-2) at index 0.
  assign cur_p0 = {pix_p0, lb_q[DATA_W-1:0], lb_q[2*DATA_W-1:DATA_W]};

  // Shift the window left by one column for every processed pixel.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      wl_p1 <= wm_p1;
      wm_p1 <= cur_p0;
    end
  end

  // Gradients, magnitude and output-mode selection for the current window.
  always_comb begin
    gx = (ext(cur_p0[0]) + (ext(cur_p0[1]) <<< 1) + ext(cur_p0[2]))
       - (ext(wl_p1[0])  + (ext(wl_p1[1])  <<< 1) + ext(wl_p1[2]));
    gy = (ext(wl_p1[2])  + (ext(wm_p1[2])  <<< 1) + ext(cur_p0[2]))
       - (ext(wl_p1[0])  + (ext(wm_p1[0])  <<< 1) + ext(cur_p0[0]));
    mag      = abs_g(gx) + abs_g(gy);
    mode_out = '0;
    case (mode_q)
      MODE_THRESH: mode_out = thresh_mag(mag, thr_q);
      MODE_SAT:    mode_out = sat_mag(mag);
      MODE_SHIFT:  mode_out = shift_mag(mag);
      MODE_PASS:   mode_out = wm_p1[1];
      default:     mode_out = '0;
    endcase
  end

  // ---- stage p1: registered output ----

  // Output register; reset discards any pixels still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sof_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      sof_p1 <= vld_p0 && sof_p0;
      if (vld_p0) begin
        data_p1 <= border_p0 ? '0 : mode_out;
      end
    end
  end

  assign out_s.valid = vld_p1;
  assign out_s.sof   = sof_p1;
  assign out_s.data  = data_p1;

endmodule
